npc_btb: RTL and testbench
==========================

Name: npc_btb

Overview:
- Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Owns the architectural fetch PC register and predicts the next fetch address each cycle.
- Accepts branch/jump resolution updates and mispredict redirects from the ID/EX resolution point.
- Applies exception-handler and ERET redirects with fixed priority.
- Parametrised successor of the combinational ID-stage NPC logic.

Parameters:
- ENTRIES, 16, BTB entries; power of two, >=2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- RESET_PC, 30'h00000C00, fetch PC word address after reset (byte 0x3000).
- EXC_ADDR, 30'h00001060, exception handler word address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hold fetch PC (pipeline stall).
- pc  out  30  current fetch PC [31:2] (registered).
- pred_taken  out  1  BTB predicts current pc redirects.
- pred_target  out  30  predicted target for current pc; 0 when no hit.
- upd_valid  in  1  resolution update strobe.
- upd_pc  in  30  PC [31:2] of the resolved control instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  30  resolved target [31:2].
- upd_cond  in  1  1 = conditional branch, 0 = unconditional jump (j/jal/jr).
- redirect_valid  in  1  mispredict; fetch restarts at redirect_pc.
- redirect_pc  in  30  correct PC [31:2].
- exc_valid  in  1  go to exception handler.
- eret_valid  in  1  return from exception.
- epc  in  30  EPC [31:2].
- mispred_cnt  out  32  count of redirect_valid cycles (performance counter).

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC.
  - All BTB valid bits = 0, all counters = 2'b01.
  - mispred_cnt = 0.
  - Therefore pred_taken = 0 and pred_target = 0.
- Lookup (combinational on registered pc):
  - idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - hit = valid[idx] && tag_mem[idx] == tag.
  - pred_taken = hit && cnt[idx][1].
  - pred_target = hit ? tgt[idx] : 0.
- Next PC, highest priority first:
  1. exc_valid -> EXC_ADDR
  2. eret_valid -> epc
  3. redirect_valid -> redirect_pc
  4. stall -> pc (hold)
  5. pred_taken -> pred_target
  6. otherwise pc+1, wrapping modulo 2^30.
- Exception, ERET and redirect override stall. pc updates one cycle after the asserting edge (latency 1).
- BTB update on upd_valid, written at the clock edge and independent of stall and redirect:
  - Entry index and tag are taken from upd_pc.
  - Hit and upd_cond:
    - cnt saturating +1 if taken, -1 if not taken; floor 00, ceiling 11.
    - tgt = upd_target if taken.
  - Hit and !upd_cond: cnt = 11, tgt = upd_target.
  - Miss and upd_taken: allocate the entry, overwriting any alias.
    - valid = 1, tag written, tgt = upd_target.
    - cnt = 10 for a conditional branch, 11 for a jump.
  - Miss and !upd_taken: no change.
- Same-cycle lookup and update at the same index: the lookup uses pre-update contents; the new contents are visible the following cycle.
- mispred_cnt increments by 1 per cycle with redirect_valid = 1, including cycles where exc_valid masks the redirect. It wraps at 2^32.
- Asserting rst_n low mid-operation immediately forces all reset values; no partial update completes.

Test Plan:
- Reset, then release with stall = 0 and no updates -> pc sequence 0x0C00, 0x0C01, 0x0C02; pred_taken = 0 throughout.
- upd_valid with upd_pc = 0x0C04, taken, target 0x0C00, cond -> pc loops 0x0C00..0x0C04 then 0x0C00; pred_taken = 1 at 0x0C04.
- Three not-taken updates on that entry -> cnt 10 -> 01 -> 00 -> 00 (saturates); pred_taken = 0; fetch falls through to 0x0C05.
- Alias test (ENTRIES = 16): entry at 0x0C04 trained, then lookup at 0x0D04 (same index, different tag) -> hit = 0, pc+1. Taken update at 0x0D04 evicts 0x0C04.
- Same cycle exc_valid, eret_valid (epc = 0x0C10), redirect_valid (0x0C20), stall -> pc = 0x1060; mispred_cnt +1. Next cycle, eret alone -> pc = 0x0C10.
- stall held with upd_valid -> pc frozen, BTB still updated. Then assert rst_n low mid-stall -> pc = 0x0C00 immediately, mispred_cnt = 0, all predictions cleared.

Source files
------------

// File: rtl/npc_btb.sv
// npc_btb: fetch-stage next-PC generator with a direct-mapped branch target
// buffer and 2-bit saturating direction counters.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hold the fetch PC
//   pc                    registered fetch PC (word address, byte bits [31:2])
//   pred_taken            BTB predicts the current pc redirects
//   pred_target           predicted target for pc, zero when the lookup misses
//   upd_*                 branch/jump resolution update from ID/EX
//   redirect_valid/_pc    mispredict redirect
//   exc_valid             jump to the exception handler
//   eret_valid, epc       return from exception
//   mispred_cnt           count of cycles with redirect_valid high
module npc_btb #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned TAG_W    = 8,
  parameter logic [29:0] RESET_PC = 30'h00000C00,
  parameter logic [29:0] EXC_ADDR = 30'h00001060
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [29:0] pc,
  output logic        pred_taken,
  output logic [29:0] pred_target,
  input  logic        upd_valid,
  input  logic [29:0] upd_pc,
  input  logic        upd_taken,
  input  logic [29:0] upd_target,
  input  logic        upd_cond,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [29:0] epc,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic             valid_r [ENTRIES];
  logic [TAG_W-1:0] tag_r   [ENTRIES];
  logic [29:0]      tgt_r   [ENTRIES];
  logic [1:0]       cnt_r   [ENTRIES];

  logic [29:0]      pc_r;
  logic [31:0]      mispred_r;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic             pred_taken_s;
  logic [29:0]      pred_target_s;
  logic [29:0]      pc_next_s;

  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             up_we_s;
  logic [1:0]       up_cnt_s;
  logic [29:0]      up_tgt_s;

  // Word address bit 0 is byte address bit 2, so the index starts at bit 0.
  assign lk_idx_s = pc_r[IDX_W-1:0];
  assign lk_tag_s = pc_r[IDX_W+TAG_W-1:IDX_W];
  assign up_idx_s = upd_pc[IDX_W-1:0];
  assign up_tag_s = upd_pc[IDX_W+TAG_W-1:IDX_W];

  // Upper PC bits above the tag do not participate in lookup.
  generate
    if (IDX_W + TAG_W < 30) begin : g_unused
      logic unused_s;
      assign unused_s = ^upd_pc[29:IDX_W+TAG_W];
    end
  endgenerate

  // BTB lookup on the registered fetch PC.
  always_comb begin
    lk_hit_s      = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    pred_taken_s  = lk_hit_s && cnt_r[lk_idx_s][1];
    if (lk_hit_s) begin
      pred_target_s = tgt_r[lk_idx_s];
    end else begin
      pred_target_s = 30'd0;
    end
  end

  // Next fetch PC selection; exception/eret/redirect override stall.
  always_comb begin
    pc_next_s = pc_r + 30'd1;
    if (exc_valid) begin
      pc_next_s = EXC_ADDR;
    end else if (eret_valid) begin
      pc_next_s = epc;
    end else if (redirect_valid) begin
      pc_next_s = redirect_pc;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (pred_taken_s) begin
      pc_next_s = pred_target_s;
    end else begin
      pc_next_s = pc_r + 30'd1;
    end
  end

  // New entry contents for a resolution update.
  always_comb begin
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    up_we_s  = 1'b0;
    up_cnt_s = cnt_r[up_idx_s];
    up_tgt_s = tgt_r[up_idx_s];
    if (upd_valid) begin
      if (up_hit_s) begin
        up_we_s = 1'b1;
        if (upd_cond) begin
          if (upd_taken) begin
            up_cnt_s = (cnt_r[up_idx_s] == 2'b11) ? 2'b11 : cnt_r[up_idx_s] + 2'd1;
            up_tgt_s = upd_target;
          end else begin
            up_cnt_s = (cnt_r[up_idx_s] == 2'b00) ? 2'b00 : cnt_r[up_idx_s] - 2'd1;
          end
        end else begin
          up_cnt_s = 2'b11;
          up_tgt_s = upd_target;
        end
      end else if (upd_taken) begin
        // Allocate, evicting whatever aliased into this slot.
        up_we_s  = 1'b1;
        up_cnt_s = upd_cond ? 2'b10 : 2'b11;
        up_tgt_s = upd_target;
      end else begin
        up_we_s = 1'b0;
      end
    end else begin
      up_we_s = 1'b0;
    end
  end

  // BTB storage; updates are independent of stall and redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= '0;
        tgt_r[i]   <= 30'd0;
        cnt_r[i]   <= 2'b01;
      end
    end else if (up_we_s) begin
      valid_r[up_idx_s] <= 1'b1;
      tag_r[up_idx_s]   <= up_tag_s;
      tgt_r[up_idx_s]   <= up_tgt_s;
      cnt_r[up_idx_s]   <= up_cnt_s;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Mispredict counter counts every redirect cycle, even when masked by an exception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_r <= 32'd0;
    end else if (redirect_valid) begin
      mispred_r <= mispred_r + 32'd1;
    end
  end

  assign pc          = pc_r;
  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;
  assign mispred_cnt = mispred_r;

endmodule

// File: tb/tb_npc_btb.sv
// Self-checking bench for npc_btb: directed scenarios followed by random
// traffic, all checked against a behavioural model of the fetch PC and BTB.
module tb_npc_btb;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [29:0] pc;
  logic        pred_taken;
  logic [29:0] pred_target;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_cond;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        exc_valid;
  logic        eret_valid;
  logic [29:0] epc;
  logic [31:0] mispred_cnt;

  int total;
  int bad;

  npc_btb dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_cond(upd_cond),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
    .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 16 entries, 8-bit tags, counters held as plain ints.
  bit          m_v   [16];
  int          m_tag [16];
  bit [29:0]   m_tgt [16];
  int          m_cnt [16];
  bit [29:0]   m_pc;
  bit [31:0]   m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input bit [29:0] a);
    return int'(a % 30'd16);
  endfunction

  function automatic int tag_of(input bit [29:0] a);
    return int'((a / 30'd16) % 30'd256);
  endfunction

  function automatic bit m_hit(input bit [29:0] a);
    return m_v[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic bit m_ptaken();
    return m_hit(m_pc) && (m_cnt[idx_of(m_pc)] >= 2);
  endfunction

  function automatic bit [29:0] m_ptarget();
    return m_hit(m_pc) ? m_tgt[idx_of(m_pc)] : 30'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 30'd0; m_cnt[i] = 1;
    end
    m_pc  = 30'h00000C00;
    m_mis = 32'd0;
  endtask

  task automatic idle();
    stall = 1'b0; upd_valid = 1'b0; upd_pc = 30'd0; upd_taken = 1'b0;
    upd_target = 30'd0; upd_cond = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 30'd0; exc_valid = 1'b0; eret_valid = 1'b0; epc = 30'd0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".pc"}, {2'b00, pc}, {2'b00, m_pc});
    chk({where, ".ptaken"}, {31'd0, pred_taken}, {31'd0, m_ptaken()});
    chk({where, ".ptarget"}, {2'b00, pred_target}, {2'b00, m_ptarget()});
    chk({where, ".mispred"}, mispred_cnt, m_mis);
  endtask

  // Advance one clock: model the edge from the currently driven inputs, then compare.
  task automatic tick(input string where);
    bit [29:0] nxt;
    int        i;
    if (exc_valid)           nxt = 30'h00001060;
    else if (eret_valid)     nxt = epc;
    else if (redirect_valid) nxt = redirect_pc;
    else if (stall)          nxt = m_pc;
    else if (m_ptaken())     nxt = m_ptarget();
    else                     nxt = m_pc + 30'd1;
    if (upd_valid) begin
      i = idx_of(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_cond) begin
          if (upd_taken) begin
            m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            m_tgt[i] = upd_target;
          end else begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          end
        end else begin
          m_cnt[i] = 3;
          m_tgt[i] = upd_target;
        end
      end else if (upd_taken) begin
        m_v[i]   = 1'b1;
        m_tag[i] = tag_of(upd_pc);
        m_tgt[i] = upd_target;
        m_cnt[i] = upd_cond ? 2 : 3;
      end
    end
    if (redirect_valid) m_mis = m_mis + 32'd1;
    m_pc = nxt;
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  function automatic bit [29:0] pick_pc();
    case ($urandom_range(0, 5))
      0:       return 30'h00000D00 + 30'($urandom_range(0, 7));
      1:       return 30'h00001060 + 30'($urandom_range(0, 7));
      default: return 30'h00000C00 + 30'($urandom_range(0, 23));
    endcase
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    idle();
    m_reset();
    rst_n = 1'b0;
    #12;
    chk("reset.pc", {2'b00, pc}, 32'h00000C00);
    chk("reset.ptaken", {31'd0, pred_taken}, 32'd0);
    chk("reset.ptarget", {2'b00, pred_target}, 32'd0);
    chk("reset.mispred", mispred_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential fetch.
    tick("seq1"); chk("seq1.c", {2'b00, pc}, 32'h00000C01);
    tick("seq2"); chk("seq2.c", {2'b00, pc}, 32'h00000C02);

    // Train a loop back-edge at 0x0C04 -> 0x0C00.
    upd_valid = 1'b1; upd_pc = 30'h00000C04; upd_taken = 1'b1;
    upd_target = 30'h00000C00; upd_cond = 1'b1;
    tick("train");
    idle();
    tick("loop1");
    chk("loop.at_c04", {2'b00, pc}, 32'h00000C04);
    chk("loop.ptaken", {31'd0, pred_taken}, 32'd1);
    chk("loop.ptarget", {2'b00, pred_target}, 32'h00000C00);
    tick("loop2"); chk("loop.back", {2'b00, pc}, 32'h00000C00);

    // Three not-taken updates saturate the counter at 00.
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1; upd_pc = 30'h00000C04; upd_taken = 1'b0; upd_cond = 1'b1;
      tick("nt");
    end
    idle();
    tick("nt.at");
    chk("nt.pc", {2'b00, pc}, 32'h00000C04);
    chk("nt.ptaken", {31'd0, pred_taken}, 32'd0);
    tick("nt.fall"); chk("nt.fall.pc", {2'b00, pc}, 32'h00000C05);

    // Alias: 0x0D04 shares index with 0x0C04 but not the tag.
    redirect_valid = 1'b1; redirect_pc = 30'h00000D04;
    tick("alias.go"); idle();
    chk("alias.nohit", {2'b00, pred_target}, 32'd0);
    upd_valid = 1'b1; upd_pc = 30'h00000D04; upd_taken = 1'b1;
    upd_target = 30'h00000D00; upd_cond = 1'b1;
    tick("alias.alloc"); idle();
    redirect_valid = 1'b1; redirect_pc = 30'h00000C04;
    tick("alias.c04"); idle();
    chk("alias.evicted", {2'b00, pred_target}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 30'h00000D04;
    tick("alias.d04"); idle();
    chk("alias.hit", {2'b00, pred_target}, 32'h00000D00);

    // Priority: exception beats eret, redirect and stall; redirect still counted.
    exc_valid = 1'b1; eret_valid = 1'b1; epc = 30'h00000C10;
    redirect_valid = 1'b1; redirect_pc = 30'h00000C20; stall = 1'b1;
    tick("prio");
    chk("prio.pc", {2'b00, pc}, 32'h00001060);
    idle();
    eret_valid = 1'b1; epc = 30'h00000C10;
    tick("eret");
    chk("eret.pc", {2'b00, pc}, 32'h00000C10);

    // Stall with an update: pc frozen, new entry visible next cycle.
    idle();
    stall = 1'b1; upd_valid = 1'b1; upd_pc = 30'h00000C10; upd_taken = 1'b1;
    upd_target = 30'h00000C30; upd_cond = 1'b0;
    tick("stall.upd");
    chk("stall.frozen", {2'b00, pc}, 32'h00000C10);
    chk("stall.pred", {2'b00, pred_target}, 32'h00000C30);
    upd_valid = 1'b0;
    tick("stall.hold");

    // Asynchronous reset mid-stall.
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.pc", {2'b00, pc}, 32'h00000C00);
    chk("arst.mispred", mispred_cnt, 32'd0);
    chk("arst.ptaken", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    check_outputs("arst.release");

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      stall          = ($urandom_range(0, 5) == 0);
      upd_valid      = ($urandom_range(0, 2) == 0);
      upd_pc         = pick_pc();
      upd_taken      = 1'($urandom_range(0, 1));
      upd_target     = pick_pc();
      upd_cond       = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = pick_pc();
      exc_valid      = ($urandom_range(0, 49) == 0);
      eret_valid     = ($urandom_range(0, 49) == 0);
      epc            = pick_pc();
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
